// File: rtl/riscv_pipe_pkg.sv
// Shared constants and types for the five-stage RV32I pipeline control logic.
package riscv_pipe_pkg;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  localparam logic [1:0] RESULTSRC_LOAD = 2'b01;

  typedef enum logic {
    IDLE  = 1'b0,
    STALL = 1'b1
  } hz_state_t;

endpackage

// File: rtl/fwd_sel.sv
// Combinational ALU operand-forwarding select for one EX-stage source register.
module fwd_sel
  import riscv_pipe_pkg::*;
#(
  parameter int unsigned REG_ADDR_W = 5
) (
  input  logic [REG_ADDR_W-1:0] rs,
  input  logic [REG_ADDR_W-1:0] rd_m,
  input  logic                  regwrite_m,
  input  logic [REG_ADDR_W-1:0] rd_w,
  input  logic                  regwrite_w,
  output logic [1:0]            fwd
);

  // MEM is the younger producer, so it wins over WB; x0 is never forwarded.
  always_comb begin
    fwd = FWD_RF;
    if (regwrite_m && (rd_m != '0) && (rd_m == rs)) begin
      fwd = FWD_MEM;
    end else if (regwrite_w && (rd_w != '0) && (rd_w == rs)) begin
      fwd = FWD_WB;
    end
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard/forwarding controller: operand forwarding, load-use stalls, redirect flushes.
// Optional perf counters (stall_cnt, flush_cnt) enabled by defining HAZARD_PERF_EN.
module pipeline_hazard_ctrl
  import riscv_pipe_pkg::*;
#(
  parameter int unsigned REG_ADDR_W = 5,
  parameter int unsigned LOAD_STALL = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] rs1_d,
  input  logic [REG_ADDR_W-1:0] rs2_d,
  input  logic                  use_rs1_d,
  input  logic                  use_rs2_d,
  input  logic [REG_ADDR_W-1:0] rs1_e,
  input  logic [REG_ADDR_W-1:0] rs2_e,
  input  logic [REG_ADDR_W-1:0] rd_e,
  input  logic                  regwrite_e,
  input  logic [1:0]            resultsrc_e,
  input  logic                  pcsrc_e,
  input  logic [REG_ADDR_W-1:0] rd_m,
  input  logic [REG_ADDR_W-1:0] rd_w,
  input  logic                  regwrite_m,
  input  logic                  regwrite_w,
  output logic [1:0]            fwd_a_e,
  output logic [1:0]            fwd_b_e,
  output logic                  stall_f,
  output logic                  stall_d,
  output logic                  flush_d,
`ifdef HAZARD_PERF_EN
  output logic                  flush_e,
  output logic [31:0]           stall_cnt,
  output logic [31:0]           flush_cnt
`else
  output logic                  flush_e
`endif
);

  localparam logic [2:0] CntLoad = 3'(LOAD_STALL - 1);

  hz_state_t  state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic       lu;
  logic       stall;
  logic [1:0] fwd_a, fwd_b;

  fwd_sel #(
    .REG_ADDR_W (REG_ADDR_W)
  ) u_fwd_a (
    .rs         (rs1_e),
    .rd_m       (rd_m),
    .regwrite_m (regwrite_m),
    .rd_w       (rd_w),
    .regwrite_w (regwrite_w),
    .fwd        (fwd_a)
  );

  fwd_sel #(
    .REG_ADDR_W (REG_ADDR_W)
  ) u_fwd_b (
    .rs         (rs2_e),
    .rd_m       (rd_m),
    .regwrite_m (regwrite_m),
    .rd_w       (rd_w),
    .regwrite_w (regwrite_w),
    .fwd        (fwd_b)
  );

  // regwrite_e is implied by a load and is not needed for detection.
  logic unused_regwrite_e;
  assign unused_regwrite_e = regwrite_e;

  assign lu = (resultsrc_e == RESULTSRC_LOAD) && (rd_e != '0) &&
              ((use_rs1_d && (rs1_d == rd_e)) || (use_rs2_d && (rs2_d == rd_e)));

  // cnt holds the stall cycles still owed, including the current one.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    stall   = 1'b0;
    if (pcsrc_e) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (lu) begin
            stall = 1'b1;
            if (LOAD_STALL > 1) begin
              state_d = STALL;
              cnt_d   = CntLoad;
            end
          end
        end
        STALL: begin
          stall = 1'b1;
          if (cnt_q <= 3'd1) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q - 3'd1;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign fwd_a_e = rst ? FWD_RF : fwd_a;
  assign fwd_b_e = rst ? FWD_RF : fwd_b;
  assign stall_f = !rst && stall;
  assign stall_d = !rst && stall;
  assign flush_d = !rst && pcsrc_e;
  assign flush_e = !rst && (stall || pcsrc_e);

`ifdef HAZARD_PERF_EN
  logic [31:0] stall_cnt_q, flush_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (stall_d) stall_cnt_q <= stall_cnt_q + 32'd1;
      if (pcsrc_e) flush_cnt_q <= flush_cnt_q + 32'd1;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`endif

endmodule
